// File: rtl/vote_session_ctrl.sv
// Debounced N-voter session controller: open/close by buttons, serial tally on close,
// verdict and count held on the LEDs until the next session opens.
module vote_session_ctrl #(
  parameter int N_VOTERS   = 3,
  parameter int DEB_CYCLES = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_VOTERS-1:0]               sw,
  input  logic                              btn_start,
  input  logic                              btn_close,
  input  logic [1:0]                        mode,
  output logic                              led_result,
  output logic                              led_tie,
  output logic                              led_valid,
  output logic [$clog2(N_VOTERS+1)-1:0]     vote_count,
  output logic                              busy
);
  localparam int CW = $clog2(N_VOTERS + 1);
  localparam int XW = CW + 2;
  localparam int NI = N_VOTERS + 2;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, VOTE, COUNT, DONE} state_t;

  logic [NI-1:0] raw, sync1, sync2, deb;
  logic [DW-1:0] deb_cnt [NI];
  logic          start_q, close_q, start_p, close_p;
  state_t        state, state_nx;
  logic [N_VOTERS-1:0] snap;
  logic [1:0]    mode_r;
  logic [CW-1:0] acc, idx;
  logic [XW-1:0] acc_w, n_w;
  logic          res_c, tie_c;

  assign raw = {btn_close, btn_start, sw};

  // Two-flop synchroniser followed by a per-bit stability counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      for (int i = 0; i < NI; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < NI; i++) begin
        if (sync2[i] != deb[i]) begin
          if (deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
            deb[i]     <= sync2[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DW'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_q <= 1'b0;
      close_q <= 1'b0;
    end else begin
      start_q <= deb[N_VOTERS];
      close_q <= deb[N_VOTERS+1];
    end
  end

  assign start_p = deb[N_VOTERS]   & ~start_q;
  assign close_p = deb[N_VOTERS+1] & ~close_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_p) state_nx = VOTE;
      VOTE:  if (close_p) state_nx = COUNT;
      COUNT: if (idx == CW'(N_VOTERS)) state_nx = DONE;
      DONE:  if (start_p) state_nx = VOTE;
      default: state_nx = IDLE;
    endcase
  end

  // Widened so 3*count and 2*N never overflow.
  assign acc_w = XW'(acc);
  assign n_w   = XW'(N_VOTERS);

  always_comb begin
    res_c = 1'b0;
    tie_c = 1'b0;
    case (mode_r)
      2'b01:   res_c = (XW'(3) * acc_w) >= (XW'(2) * n_w);
      2'b10:   res_c = (acc_w == n_w);
      default: begin
        res_c = (acc_w << 1) > n_w;
        tie_c = (acc_w << 1) == n_w;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      snap       <= '0;
      mode_r     <= '0;
      acc        <= '0;
      idx        <= '0;
      vote_count <= '0;
      led_result <= 1'b0;
      led_tie    <= 1'b0;
      led_valid  <= 1'b0;
    end else begin
      case (state)
        VOTE: if (close_p) begin
          snap   <= deb[N_VOTERS-1:0];
          mode_r <= mode;
          acc    <= '0;
          idx    <= '0;
        end
        COUNT: begin
          // Snapshot shifts out LSB-first; the extra cycle at idx==N publishes the result.
          if (idx != CW'(N_VOTERS)) begin
            acc  <= acc + CW'(snap[0]);
            snap <= snap >> 1;
            idx  <= idx + CW'(1);
          end else begin
            vote_count <= acc;
            led_result <= res_c;
            led_tie    <= tie_c;
            led_valid  <= 1'b1;
          end
        end
        DONE: if (start_p) begin
          vote_count <= '0;
          led_result <= 1'b0;
          led_tie    <= 1'b0;
          led_valid  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == VOTE) || (state == COUNT);

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: a 3-voter and a 4-voter instance driven in lock-step,
// checked against an arithmetic verdict model on directed and random sessions.
module tb_vote_session_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw3;
  logic [3:0] sw4;
  logic       btn_start, btn_close;
  logic [1:0] mode;
  logic       res3, tie3, val3, busy3;
  logic       res4, tie4, val4, busy4;
  logic [1:0] cnt3;
  logic [2:0] cnt4;
  int         n_assert = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  vote_session_ctrl #(.N_VOTERS(3), .DEB_CYCLES(4)) dut3 (
    .clk(clk), .rst(rst), .sw(sw3), .btn_start(btn_start), .btn_close(btn_close),
    .mode(mode), .led_result(res3), .led_tie(tie3), .led_valid(val3),
    .vote_count(cnt3), .busy(busy3));

  vote_session_ctrl #(.N_VOTERS(4), .DEB_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst), .sw(sw4), .btn_start(btn_start), .btn_close(btn_close),
    .mode(mode), .led_result(res4), .led_tie(tie4), .led_valid(val4),
    .vote_count(cnt4), .busy(busy4));

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Verdict rules stated as fractions of the electorate, cross-multiplied to stay integral.
  function automatic void model(input int yes, input int n, input logic [1:0] m,
                                output logic r, output logic t);
    int no;
    no = n - yes;
    case (m)
      2'b01:   begin r = (yes * 3 >= n * 2); t = 1'b0; end
      2'b10:   begin r = (no == 0);          t = 1'b0; end
      default: begin r = (yes > no);         t = (yes == no); end
    endcase
  endfunction

  task automatic press_start();
    btn_start = 1'b1;
    step(8);
    btn_start = 1'b0;
    step(8);
  endtask

  task automatic session(input logic [2:0] s3, input logic [3:0] s4,
                         input logic [1:0] m, input bit both);
    int   c3, c4;
    logic r3, t3, r4, t4;
    c3 = $countones(s3);
    c4 = $countones(s4);
    model(c3, 3, m, r3, t3);
    model(c4, 4, m, r4, t4);
    sw3 = s3; sw4 = s4; mode = m;
    step(12);
    press_start();
    check("open_busy3", busy3, 1); check("open_valid3", val3, 0);
    check("open_cnt3", cnt3, 0);   check("open_res3", res3, 0);
    check("open_busy4", busy4, 1); check("open_valid4", val4, 0);
    // 3-cycle close glitch and a repeat start must both leave the session open.
    btn_close = 1'b1; step(3); btn_close = 1'b0; step(10);
    press_start();
    check("vote_busy3", busy3, 1); check("vote_valid3", val3, 0);
    check("vote_busy4", busy4, 1);
    // Raw close rises at edge E; close_p is sampled at E+7 (2 sync + 4 debounce + edge reg).
    btn_close = 1'b1;
    if (both) btn_start = 1'b1;
    sw3[0] = ~s3[0];
    step(3);
    sw3 = s3;
    step(5);
    sw3 = ~s3; sw4 = ~s4; mode = ~m;
    step(2);
    check("lat_pre_valid3", val3, 0); check("lat_pre_busy3", busy3, 1);
    step(1);
    check("lat_valid3", val3, 1); check("lat_busy3", busy3, 0);
    check("lat_pre_valid4", val4, 0);
    step(1);
    check("lat_valid4", val4, 1);
    btn_close = 1'b0; btn_start = 1'b0;
    step(8);
    check("cnt3", cnt3, c3); check("res3", res3, r3); check("tie3", tie3, t3);
    check("cnt4", cnt4, c4); check("res4", res4, r4); check("tie4", tie4, t4);
    check("done_valid3", val3, 1); check("done_busy4", busy4, 0);
  endtask

  initial begin
    rst = 1'b1; sw3 = '0; sw4 = '0; btn_start = 1'b0; btn_close = 1'b0; mode = '0;
    step(3);
    rst = 1'b0;
    step(1);
    check("rst_valid3", val3, 0); check("rst_cnt3", cnt3, 0); check("rst_busy3", busy3, 0);
    check("rst_res3", res3, 0);   check("rst_tie3", tie3, 0);
    check("rst_valid4", val4, 0); check("rst_cnt4", cnt4, 0); check("rst_busy4", busy4, 0);

    btn_close = 1'b1; step(8); btn_close = 1'b0; step(8);
    check("idle_close_busy3", busy3, 0); check("idle_close_valid3", val3, 0);

    session(3'b101, 4'b0110, 2'b00, 1'b0);
    session(3'b111, 4'b0111, 2'b00, 1'b0);
    session(3'b000, 4'b0000, 2'b00, 1'b0);
    session(3'b100, 4'b1111, 2'b00, 1'b1);
    session(3'b101, 4'b1010, 2'b10, 1'b0);
    session(3'b101, 4'b1110, 2'b01, 1'b0);
    session(3'b011, 4'b0001, 2'b11, 1'b1);

    // Reset during the second COUNT cycle: next edge must show IDLE with cleared outputs.
    sw3 = 3'b101; sw4 = 4'b1011; mode = 2'b00;
    step(12);
    press_start();
    btn_close = 1'b1;
    step(8);
    rst = 1'b1;
    step(1);
    check("midrst_busy3", busy3, 0); check("midrst_valid3", val3, 0);
    check("midrst_cnt3", cnt3, 0);   check("midrst_res3", res3, 0);
    check("midrst_tie3", tie3, 0);   check("midrst_busy4", busy4, 0);
    check("midrst_valid4", val4, 0);
    rst = 1'b0; btn_close = 1'b0;
    step(10);
    check("postrst_valid3", val3, 0); check("postrst_busy3", busy3, 0);
    check("postrst_valid4", val4, 0);
    session(3'b101, 4'b1011, 2'b00, 1'b0);

    for (int k = 0; k < 8; k++)
      session(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/vote_session_ctrl.md
Name: vote_session_ctrl

Overview:
- Parametrised successor to the 3-input majority voter: N voter switches, debounced, with vote sessions opened and closed by buttons.
- On close, the block snapshots the votes and counts them serially. It then holds the pass/tie verdict and tally on the LEDs until the next session.
- It sits between the board switches/buttons and the LED outputs, replacing the bare combinational voter.

Parameters:
- N_VOTERS, 3, number of voter switches (any value 2..16; even values allow ties).
- DEB_CYCLES, 4, consecutive stable cycles required before a debounced input changes (≥1; board builds set about 1_000_000).
- CW, $clog2(N_VOTERS+1), tally width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sw  input  N_VOTERS  raw voter switches, asynchronous to clk; bit i = voter i, 1 = yes.
- btn_start  input  1  raw button, opens a session.
- btn_close  input  1  raw button, closes the session and triggers the count.
- mode  input  2  verdict rule, sampled at close: 00 simple majority, 01 two-thirds, 10 unanimous, 11 = majority.
- led_result  output  1  verdict: 1 = motion passes.
- led_tie  output  1  yes count equals no count (majority modes only).
- led_valid  output  1  verdict and tally outputs are valid.
- vote_count  output  CW  number of yes votes in the snapshot.
- busy  output  1  high in VOTE or COUNT state.

Behaviour:
- Sync: every raw input passes through a 2-flop synchroniser before its debouncer.
- Debounce (per signal):
  - Counter increments while the synced input differs from the debounced value, and clears when they match.
  - The debounced value flips when the counter reaches DEB_CYCLES−1 while still differing; the counter then clears.
  - Pulses shorter than DEB_CYCLES cycles never propagate.
- Button edges: start_p and close_p are 1-cycle pulses on the rising edge of the debounced button.
- Reset: all debounced values, counters and outputs go to 0; state = IDLE.
- FSM states: IDLE, VOTE, COUNT, DONE.
  - IDLE: start_p → VOTE. close_p is ignored.
  - VOTE:
    - busy=1; switches may change freely.
    - close_p → COUNT. On that same edge, load snap ← debounced sw, mode_r ← mode, acc ← 0, idx ← 0.
    - close_p takes priority over a simultaneous start_p; start_p alone is ignored.
  - COUNT:
    - One bit per cycle: acc ← acc + snap[idx], idx ← idx+1. N_VOTERS cycles in total.
    - Switch changes, start_p and close_p are all ignored.
    - On the edge that ends the last COUNT cycle: state → DONE, vote_count ← final acc, verdict registered, led_valid ← 1.
  - DONE:
    - Outputs held stable.
    - start_p → VOTE and clears led_valid, led_result, led_tie and vote_count to 0 on that edge.
- Latency: led_valid rises exactly N_VOTERS+1 clk edges after the edge on which close_p is sampled in VOTE.
- Verdict arithmetic (widen operands to CW+2 bits, no overflow):
  - Majority: result = (2·count > N); tie = (2·count == N).
  - Two-thirds: result = (3·count ≥ 2·N); tie = 0.
  - Unanimous: result = (count == N); tie = 0.
- Outputs are registered and change only at the events above.
- rst asserted in any state, including mid-COUNT, returns to IDLE with all outputs 0 on the next edge; no partial verdict appears.

Test Plan:
- N=3, DEB=4, mode=00: sw=101 debounced, start, close → led_valid exactly 4 edges after close_p, vote_count=2, led_result=1, led_tie=0.
- N=3, mode=00: run sessions with sw=111, then 000, then 100 → (count,result) = (3,1), (0,0), (1,0). Between sessions led_valid drops on start_p.
- N=3, mode=10, sw=101 → count=2, result=0. Same snapshot with mode=01 → result=1.
- N=4, mode=00: sw=0110 → count=2, result=0, tie=1. sw=0111 → count=3, result=1, tie=0.
- Debounce and ignore rules:
  - 3-cycle glitch on sw[0] or btn_close → no change, no close.
  - Switch toggle during COUNT → tally still matches the snapshot taken at close.
  - Simultaneous start and close in VOTE → enters COUNT.
- Reset: rst pulsed during the 2nd COUNT cycle → next edge IDLE, all outputs 0. A later full session with sw=101 gives count=2, result=1.
